// File: rtl/mc_ctrl_if.sv
// Bundle of IR fields, memory handshake and datapath controls between the
// multi-cycle controller (master) and the datapath/memory side (slave).
interface mc_ctrl_if #(
    parameter int ALUOP_W  = 5,
    parameter int RETIRE_W = 32
);
    logic [5:0]          Op;
    logic [5:0]          Funct;
    logic                Zero;
    logic                mem_ready;
    logic                PCWrite;
    logic                IRWrite;
    logic                MemRead;
    logic                MemWrite;
    logic                IorD;
    logic                RegWrite;
    logic                EXTOp;
    logic                ALUSrc;
    logic [ALUOP_W-1:0]  ALUOp;
    logic [3:0]          NPCOp;
    logic [1:0]          GPRSel;
    logic [1:0]          WDSel;
    logic [3:0]          LOADSel;
    logic [2:0]          state;
    logic [1:0]          fault;
    logic                retire;
    logic [RETIRE_W-1:0] retire_cnt;

    modport master (
        input  Op, Funct, Zero, mem_ready,
        output PCWrite, IRWrite, MemRead, MemWrite, IorD, RegWrite, EXTOp, ALUSrc,
               ALUOp, NPCOp, GPRSel, WDSel, LOADSel, state, fault, retire, retire_cnt
    );

    modport slave (
        output Op, Funct, Zero, mem_ready,
        input  PCWrite, IRWrite, MemRead, MemWrite, IorD, RegWrite, EXTOp, ALUSrc,
               ALUOp, NPCOp, GPRSel, WDSel, LOADSel, state, fault, retire, retire_cnt
    );
endinterface

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS controller: FETCH/DECODE/EXEC/MEM/WB sequencing over a shared
// memory port, with memory watchdog, illegal-instruction trap and retire counter.
module mc_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int RETIRE_W    = 32,
    parameter int ALUOP_W     = 5
) (
    input  logic      clk,
    input  logic      rstn,
    mc_ctrl_if.master bus
);
    typedef enum logic [2:0] {
        S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2,
        S_MEM   = 3'd3, S_WB     = 3'd4, S_TRAP = 3'd5
    } state_t;

    localparam int WC = $clog2(MEM_TIMEOUT + 2);
    localparam logic [WC-1:0] WAIT_LIMIT = WC'(MEM_TIMEOUT);

    state_t            state_reg, state_next;
    logic [1:0]        fault_reg, fault_next;
    logic [RETIRE_W-1:0] retire_cnt_reg;
    logic [WC-1:0]     wait_cnt_reg, wait_cnt_next;

    logic legal, is_load, is_sw, is_beq, is_bne, is_j, is_jal, is_jr, is_jalr;
    logic ext_op, alu_src;
    logic [4:0] alu_code;
    logic [1:0] gpr_sel, wd_sel;
    logic [3:0] load_sel;

    always_comb begin
        legal = 1'b1; is_load = 1'b0; is_sw = 1'b0; is_beq = 1'b0; is_bne = 1'b0;
        is_j = 1'b0; is_jal = 1'b0; is_jr = 1'b0; is_jalr = 1'b0;
        ext_op = 1'b0; alu_src = 1'b0; alu_code = 5'd1;
        gpr_sel = 2'd1; wd_sel = 2'd0; load_sel = 4'd0;
        case (bus.Op)
            6'h00: begin
                gpr_sel = 2'd0;
                case (bus.Funct)
                    6'h20, 6'h21: alu_code = 5'd1;
                    6'h22, 6'h23: alu_code = 5'd2;
                    6'h24: alu_code = 5'd3;
                    6'h25: alu_code = 5'd4;
                    6'h2A: alu_code = 5'd5;
                    6'h2B: alu_code = 5'd6;
                    6'h00: alu_code = 5'd7;
                    6'h27: alu_code = 5'd8;
                    6'h02: alu_code = 5'd10;
                    6'h04: alu_code = 5'd11;
                    6'h26: alu_code = 5'd12;
                    6'h03: alu_code = 5'd13;
                    6'h07: alu_code = 5'd14;
                    6'h08: is_jr = 1'b1;
                    6'h09: begin is_jalr = 1'b1; wd_sel = 2'd2; end
                    default: legal = 1'b0;
                endcase
            end
            6'h02: is_j = 1'b1;
            6'h03: begin is_jal = 1'b1; gpr_sel = 2'd2; wd_sel = 2'd2; end
            6'h04: begin is_beq = 1'b1; ext_op = 1'b1; alu_code = 5'd2; end
            6'h05: begin is_bne = 1'b1; ext_op = 1'b1; alu_code = 5'd2; end
            6'h08: begin ext_op = 1'b1; alu_src = 1'b1; end
            6'h0A: begin ext_op = 1'b1; alu_src = 1'b1; alu_code = 5'd5; end
            6'h0C: begin alu_src = 1'b1; alu_code = 5'd3; end
            6'h0D: begin alu_src = 1'b1; alu_code = 5'd4; end
            6'h0F: begin alu_src = 1'b1; alu_code = 5'd9; end
            6'h23, 6'h20, 6'h24, 6'h21: begin
                is_load = 1'b1; ext_op = 1'b1; alu_src = 1'b1; wd_sel = 2'd1;
                load_sel = (bus.Op == 6'h20) ? 4'd1 : (bus.Op == 6'h24) ? 4'd2 :
                           (bus.Op == 6'h21) ? 4'd3 : 4'd0;
            end
            6'h2B: begin is_sw = 1'b1; ext_op = 1'b1; alu_src = 1'b1; end
            default: legal = 1'b0;
        endcase
    end

    logic timeout;
    logic pc_wr, ir_wr, mem_rd, mem_wr, iord, reg_wr, retire_p;
    logic [3:0] npc_op;

    // The limit compares against the registered count, so a ready arriving in
    // the limit cycle is taken before the timeout branch.
    assign timeout = (MEM_TIMEOUT != 0) && (wait_cnt_reg == WAIT_LIMIT);

    always_comb begin
        state_next = state_reg; fault_next = fault_reg;
        pc_wr = 1'b0; ir_wr = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0; iord = 1'b0;
        reg_wr = 1'b0; retire_p = 1'b0; npc_op = 4'd0;
        case (state_reg)
            S_FETCH: begin
                mem_rd = 1'b1;
                if (bus.mem_ready) begin
                    ir_wr = 1'b1; pc_wr = 1'b1; state_next = S_DECODE;
                end else if (timeout) begin
                    state_next = S_TRAP; fault_next[1] = 1'b1;
                end
            end
            S_DECODE: begin
                if (!legal) begin
                    state_next = S_TRAP; fault_next[0] = 1'b1;
                end else if (is_j || is_jal) begin
                    pc_wr = 1'b1; npc_op = 4'd2; reg_wr = is_jal;
                    retire_p = 1'b1; state_next = S_FETCH;
                end else begin
                    state_next = S_EXEC;
                end
            end
            S_EXEC: begin
                if (is_beq || is_bne) begin
                    pc_wr = (is_beq & bus.Zero) | (is_bne & ~bus.Zero);
                    npc_op = 4'd1; retire_p = 1'b1; state_next = S_FETCH;
                end else if (is_jr) begin
                    pc_wr = 1'b1; npc_op = 4'd3; retire_p = 1'b1; state_next = S_FETCH;
                end else if (is_jalr) begin
                    pc_wr = 1'b1; npc_op = 4'd4; reg_wr = 1'b1;
                    retire_p = 1'b1; state_next = S_FETCH;
                end else if (is_load || is_sw) begin
                    state_next = S_MEM;
                end else begin
                    state_next = S_WB;
                end
            end
            S_MEM: begin
                iord = 1'b1; mem_rd = is_load; mem_wr = ~is_load;
                if (bus.mem_ready) begin
                    state_next = is_load ? S_WB : S_FETCH;
                    retire_p = ~is_load;
                end else if (timeout) begin
                    state_next = S_TRAP; fault_next[1] = 1'b1;
                end
            end
            S_WB: begin
                reg_wr = 1'b1; retire_p = 1'b1; state_next = S_FETCH;
            end
            default: state_next = S_TRAP;
        endcase
    end

    always_comb begin
        wait_cnt_next = wait_cnt_reg;
        if (state_next != state_reg)
            wait_cnt_next = '0;
        else if ((state_reg == S_FETCH || state_reg == S_MEM) && !bus.mem_ready
                 && MEM_TIMEOUT != 0 && wait_cnt_reg != WAIT_LIMIT)
            wait_cnt_next = wait_cnt_reg + 1'b1;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg      <= S_FETCH;
            fault_reg      <= 2'b00;
            retire_cnt_reg <= '0;
            wait_cnt_reg   <= '0;
        end else begin
            state_reg      <= state_next;
            fault_reg      <= fault_next;
            wait_cnt_reg   <= wait_cnt_next;
            if (retire_p)
                retire_cnt_reg <= retire_cnt_reg + 1'b1;
        end
    end

    // Enables are gated by rstn so they drop the instant reset asserts.
    assign bus.PCWrite    = pc_wr    & rstn;
    assign bus.IRWrite    = ir_wr    & rstn;
    assign bus.MemRead    = mem_rd   & rstn;
    assign bus.MemWrite   = mem_wr   & rstn;
    assign bus.RegWrite   = reg_wr   & rstn;
    assign bus.retire     = retire_p & rstn;
    assign bus.IorD       = iord;
    assign bus.NPCOp      = npc_op;
    assign bus.EXTOp      = ext_op;
    assign bus.ALUSrc     = alu_src;
    assign bus.ALUOp      = ALUOP_W'(alu_code);
    assign bus.GPRSel     = gpr_sel;
    assign bus.WDSel      = wd_sel;
    assign bus.LOADSel    = load_sel;
    assign bus.state      = state_reg;
    assign bus.fault      = fault_reg;
    assign bus.retire_cnt = retire_cnt_reg;
endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl: walks instruction classes through the state
// sequence and checks controls, watchdog, trap, async reset and counter wrap.
module tb_mc_ctrl;
    localparam int MEM_TIMEOUT = 4;
    localparam int RETIRE_W    = 4;
    localparam int ALUOP_W     = 5;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mc_ctrl_if #(.ALUOP_W(ALUOP_W), .RETIRE_W(RETIRE_W)) bus ();

    mc_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .RETIRE_W(RETIRE_W), .ALUOP_W(ALUOP_W)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive inputs at the falling edge, then let combinational outputs settle.
    task automatic cyc(input logic [5:0] op, input logic [5:0] fn, input logic z, input logic rdy);
        @(negedge clk);
        bus.Op = op; bus.Funct = fn; bus.Zero = z; bus.mem_ready = rdy;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0;
        bus.Op = 6'h00; bus.Funct = 6'h20; bus.Zero = 1'b0; bus.mem_ready = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
    endtask

    initial begin
        bus.Op = 6'h00; bus.Funct = 6'h20; bus.Zero = 1'b0; bus.mem_ready = 1'b0;
        #1;
        check("rst_memread", {31'd0, bus.MemRead}, 32'd0);
        check("rst_state", {29'd0, bus.state}, 32'd0);
        do_reset();
        #1;
        check("rst_fault", {30'd0, bus.fault}, 32'd0);
        check("rst_cnt", {28'd0, bus.retire_cnt}, 32'd0);

        // addi with fetch ready two cycles late
        cyc(6'h08, 6'h00, 1'b0, 1'b0);
        check("addi_f0_state", {29'd0, bus.state}, 32'd0);
        check("addi_f0_memread", {31'd0, bus.MemRead}, 32'd1);
        check("addi_f0_irwrite", {31'd0, bus.IRWrite}, 32'd0);
        cyc(6'h08, 6'h00, 1'b0, 1'b0);
        check("addi_f1_state", {29'd0, bus.state}, 32'd0);
        cyc(6'h08, 6'h00, 1'b0, 1'b1);
        check("addi_f2_irwrite", {31'd0, bus.IRWrite}, 32'd1);
        check("addi_f2_pcwrite", {31'd0, bus.PCWrite}, 32'd1);
        check("addi_f2_iord", {31'd0, bus.IorD}, 32'd0);
        cyc(6'h08, 6'h00, 1'b0, 1'b0);
        check("addi_dec_state", {29'd0, bus.state}, 32'd1);
        check("addi_dec_regwrite", {31'd0, bus.RegWrite}, 32'd0);
        check("addi_dec_decode", {23'd0, bus.ALUOp, bus.ALUSrc, bus.EXTOp, bus.GPRSel}, {23'd0, 5'd1, 1'b1, 1'b1, 2'd1});
        cyc(6'h08, 6'h00, 1'b0, 1'b0);
        check("addi_exe_state", {29'd0, bus.state}, 32'd2);
        check("addi_exe_regwrite", {31'd0, bus.RegWrite}, 32'd0);
        cyc(6'h08, 6'h00, 1'b0, 1'b0);
        check("addi_wb_state", {29'd0, bus.state}, 32'd4);
        check("addi_wb_regwrite", {31'd0, bus.RegWrite}, 32'd1);
        check("addi_wb_wdsel", {30'd0, bus.WDSel}, 32'd0);
        check("addi_wb_retire", {31'd0, bus.retire}, 32'd1);
        cyc(6'h08, 6'h00, 1'b0, 1'b0);
        check("addi_done_state", {29'd0, bus.state}, 32'd0);
        check("addi_done_retire", {31'd0, bus.retire}, 32'd0);
        check("addi_done_cnt", {28'd0, bus.retire_cnt}, 32'd1);
        $display("txn addi: state=%0d retire_cnt=%0d", bus.state, bus.retire_cnt);

        // beq taken then not taken
        for (int k = 0; k < 2; k++) begin
            logic z;
            z = (k == 0);
            cyc(6'h04, 6'h00, z, 1'b1);
            cyc(6'h04, 6'h00, z, 1'b0);
            check("beq_dec_state", {29'd0, bus.state}, 32'd1);
            cyc(6'h04, 6'h00, z, 1'b0);
            check("beq_exe_state", {29'd0, bus.state}, 32'd2);
            check("beq_exe_pcwrite", {31'd0, bus.PCWrite}, {31'd0, z});
            check("beq_exe_npcop", {28'd0, bus.NPCOp}, 32'd1);
            check("beq_exe_aluop", {27'd0, bus.ALUOp}, 32'd2);
            check("beq_exe_retire", {31'd0, bus.retire}, 32'd1);
            cyc(6'h04, 6'h00, z, 1'b0);
            check("beq_done_state", {29'd0, bus.state}, 32'd0);
            check("beq_done_cnt", {28'd0, bus.retire_cnt}, 32'd2 + k);
            $display("txn beq zero=%0d: retire_cnt=%0d", z, bus.retire_cnt);
        end

        // lb completes through WB
        cyc(6'h20, 6'h00, 1'b0, 1'b1);
        cyc(6'h20, 6'h00, 1'b0, 1'b0);
        cyc(6'h20, 6'h00, 1'b0, 1'b0);
        check("lb_exe_state", {29'd0, bus.state}, 32'd2);
        check("lb_exe_alu", {26'd0, bus.ALUOp, bus.ALUSrc}, {26'd0, 5'd1, 1'b1});
        cyc(6'h20, 6'h00, 1'b0, 1'b1);
        check("lb_mem_state", {29'd0, bus.state}, 32'd3);
        check("lb_mem_rd_iord", {30'd0, bus.MemRead, bus.IorD}, 32'd3);
        check("lb_mem_retire", {31'd0, bus.retire}, 32'd0);
        cyc(6'h20, 6'h00, 1'b0, 1'b0);
        check("lb_wb_state", {29'd0, bus.state}, 32'd4);
        check("lb_wb_sel", {26'd0, bus.RegWrite, bus.WDSel, bus.LOADSel[2:0]}, {26'd0, 1'b1, 2'd1, 3'd1});
        cyc(6'h20, 6'h00, 1'b0, 1'b0);
        check("lb_done_cnt", {28'd0, bus.retire_cnt}, 32'd4);
        $display("txn lb: retire_cnt=%0d", bus.retire_cnt);

        // illegal opcode traps in DECODE
        do_reset();
        cyc(6'h3F, 6'h00, 1'b0, 1'b1);
        cyc(6'h3F, 6'h00, 1'b0, 1'b0);
        check("ill_dec_state", {29'd0, bus.state}, 32'd1);
        check("ill_dec_pcwrite", {31'd0, bus.PCWrite}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            cyc(6'h3F, 6'h00, 1'b0, 1'b1);
            check("ill_trap_state", {29'd0, bus.state}, 32'd5);
            check("ill_trap_fault", {30'd0, bus.fault}, 32'd1);
            check("ill_trap_en", {29'd0, bus.PCWrite, bus.RegWrite, bus.MemWrite}, 32'd0);
        end
        $display("txn illegal: fault=%0b", bus.fault);

        // lw with memory stuck in MEM -> watchdog trap
        do_reset();
        cyc(6'h23, 6'h00, 1'b0, 1'b1);
        cyc(6'h23, 6'h00, 1'b0, 1'b0);
        cyc(6'h23, 6'h00, 1'b0, 1'b0);
        check("lwto_exe_state", {29'd0, bus.state}, 32'd2);
        for (int k = 0; k <= MEM_TIMEOUT; k++) begin
            cyc(6'h23, 6'h00, 1'b0, 1'b0);
            check("lwto_mem_state", {29'd0, bus.state}, 32'd3);
            check("lwto_mem_rd", {30'd0, bus.MemRead, bus.IorD}, 32'd3);
        end
        for (int k = 0; k < 20; k++) begin
            cyc(6'h23, 6'h00, 1'b0, (k == 5));
            check("lwto_trap_state", {29'd0, bus.state}, 32'd5);
            check("lwto_trap_rd", {31'd0, bus.MemRead}, 32'd0);
        end
        check("lwto_fault", {30'd0, bus.fault}, 32'd2);
        $display("txn lw timeout: fault=%0b", bus.fault);

        // sw interrupted by reset mid-MEM
        do_reset();
        cyc(6'h2B, 6'h00, 1'b0, 1'b1);
        cyc(6'h2B, 6'h00, 1'b0, 1'b0);
        cyc(6'h2B, 6'h00, 1'b0, 1'b0);
        cyc(6'h2B, 6'h00, 1'b0, 1'b0);
        check("sw_mem_state", {29'd0, bus.state}, 32'd3);
        check("sw_mem_wr", {30'd0, bus.MemWrite, bus.MemRead}, 32'd2);
        #2 rstn = 1'b0;
        #1;
        check("sw_rst_memwrite", {31'd0, bus.MemWrite}, 32'd0);
        check("sw_rst_state", {29'd0, bus.state}, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        #1;
        check("sw_rel_state", {29'd0, bus.state}, 32'd0);
        check("sw_rel_fault", {30'd0, bus.fault}, 32'd0);
        check("sw_rel_cnt", {28'd0, bus.retire_cnt}, 32'd0);
        $display("txn sw reset: state=%0d", bus.state);

        // 17 jumps wrap the 4-bit counter to 1, then jal
        for (int k = 0; k < 17; k++) begin
            cyc(6'h02, 6'h00, 1'b0, 1'b1);
            cyc(6'h02, 6'h00, 1'b0, 1'b0);
            if (k == 0) begin
                check("j_dec_state", {29'd0, bus.state}, 32'd1);
                check("j_dec_ctl", {26'd0, bus.PCWrite, bus.RegWrite, bus.NPCOp}, {26'd0, 1'b1, 1'b0, 4'd2});
            end
        end
        cyc(6'h03, 6'h00, 1'b0, 1'b0);
        check("j_wrap_cnt", {28'd0, bus.retire_cnt}, 32'd1);
        cyc(6'h03, 6'h00, 1'b0, 1'b1);
        cyc(6'h03, 6'h00, 1'b0, 1'b0);
        check("jal_dec_ctl", {25'd0, bus.PCWrite, bus.RegWrite, bus.retire, bus.GPRSel, bus.WDSel},
              {25'd0, 1'b1, 1'b1, 1'b1, 2'd2, 2'd2});
        cyc(6'h03, 6'h00, 1'b0, 1'b0);
        check("jal_done_cnt", {28'd0, bus.retire_cnt}, 32'd2);
        $display("txn jumps: retire_cnt=%0d", bus.retire_cnt);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
